// File: rtl/crc_stream_engine.sv
// crc_stream_engine: folds a framed valid/ready word stream into a CRC.
// Poly, init, reflection, final xor and bits folded per clock are parameters.
module crc_stream_engine #(
   parameter int                CRC_W        = 16,
   parameter logic [CRC_W-1:0]  POLY         = 16'h1021,
   parameter logic [CRC_W-1:0]  INIT         = '0,
   parameter logic [CRC_W-1:0]  XOR_OUT      = '0,
   parameter int                DATA_W       = 8,
   parameter int                BITS_PER_CYC = 1,
   parameter bit                REFLECT_IN   = 1'b0,
   parameter bit                REFLECT_OUT  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_first,
   input  logic              in_last,
   output logic              crc_valid,
   input  logic              crc_ready,
   output logic [CRC_W-1:0]  crc_out,
   output logic              busy
);

   localparam int N     = DATA_W / BITS_PER_CYC;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

   if (BITS_PER_CYC < 1 || (DATA_W % BITS_PER_CYC) != 0) begin : g_bpc_chk
      $error("BITS_PER_CYC must divide DATA_W");
   end
   if (CRC_W < 1 || CRC_W > 32) begin : g_w_chk
      $error("CRC_W must be within 1..32");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CRC_W-1:0]    acc_q, acc_d;
   logic [CRC_W-1:0]    crc_q, crc_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CRC_W-1:0]    fold_acc;
   logic [DATA_W-1:0]   fold_word;

   function automatic logic [DATA_W-1:0] rev_data(
      input logic [DATA_W-1:0] x
   );
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = x[DATA_W-1-i];
      end
      return r;
   endfunction

   function automatic logic [CRC_W-1:0] rev_crc(
      input logic [CRC_W-1:0] x
   );
      logic [CRC_W-1:0] r;
      r = '0;
      for (int i = 0; i < CRC_W; i++) begin
         r[i] = x[CRC_W-1-i];
      end
      return r;
   endfunction

   // Serial LFSR step unrolled BITS_PER_CYC times, word MSB first.
   always_comb begin
      logic fb;
      fold_acc  = acc_q;
      fold_word = word_q;
      fb        = 1'b0;
      for (int i = 0; i < BITS_PER_CYC; i++) begin
         fb        = fold_acc[CRC_W-1] ^ fold_word[DATA_W-1];
         fold_acc  = (fold_acc << 1) ^ (fb ? POLY : '0);
         fold_word = fold_word << 1;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      crc_d   = crc_q;
      word_d  = word_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = REFLECT_IN ? rev_data(in_data) : in_data;
               last_d  = in_last;
               cnt_d   = CNT_MAX;
               state_d = SHIFT;
               if (in_first) begin
                  acc_d = INIT;
               end
            end
         end
         SHIFT: begin
            acc_d  = fold_acc;
            word_d = fold_word;
            if (cnt_q == '0) begin
               if (last_q) begin
                  crc_d   = (REFLECT_OUT ? rev_crc(fold_acc)
                                         : fold_acc) ^ XOR_OUT;
                  state_d = DONE;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (crc_ready) begin
               acc_d   = INIT;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= INIT;
         crc_q   <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         crc_q   <= crc_d;
         word_q  <= word_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign crc_valid = (state_q == DONE);
   assign crc_out   = crc_q;
   assign busy      = (state_q != IDLE);

endmodule
